// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared defaults and the FSM state type for the memory dump reader.
//   DEF_ADDR_W / DEF_DATA_W / DEF_LEN_W : default parameter values for mem_dump_reader
//   state_t                             : IDLE -> READ -> DRAIN -> DONE -> IDLE
package mem_dump_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dump_skid.sv
// mem_dump_skid: 2-entry FIFO holding {addr,last,data} words between the memory
// read port and the output stream. Entry 0 is always the head.
//   clock, reset_n : clock / async active-low reset (empties the FIFO, zeroes entries)
//   push, din      : write din at the tail
//   pop            : drop the head (only when cnt != 0)
//   head           : current head entry (stable while not popped)
//   cnt            : number of valid entries, 0..2
// No overflow protection: the reader only issues a read when a slot is guaranteed.
module mem_dump_skid #(
  parameter int W = 45
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);

  logic [1:0][W-1:0] ent;

  assign head = ent[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent[cnt[0]] <= din;
          cnt         <= cnt + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // pop frees the head first, so a full FIFO can still take the push
          if (cnt == 2'd1) begin
            ent[0] <= din;
          end else begin
            ent[0] <= ent[1];
            ent[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: on start, streams len words from base (address wraps at
// 2**ADDR_W) out of a synchronous 1-cycle-latency memory onto a valid/ready port.
//   clock, reset_n          : clock / async active-low reset
//   start, base, len        : begin a dump (accepted only in IDLE); len==0 -> straight to DONE
//   busy, done              : busy in READ/DRAIN; done pulses one cycle at the end
//   mem_rd_en, mem_addr     : memory read strobe/address; mem_rdata valid next cycle
//   out_valid/ready/data/addr/last : output stream, out_last on word index len-1
// Optional: `define MEM_DUMP_CHECKSUM_EN adds output checksum = mod-2**DATA_W sum of
// words accepted in the current dump (cleared on accepted start).
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int EW = ADDR_W + 1 + DATA_W;

  state_t            state;
  logic [LEN_W-1:0]  rem;       // reads still to issue
  logic              inflight;  // read issued last cycle, data on mem_rdata now
  logic [ADDR_W-1:0] fl_addr;
  logic              fl_last;
  logic [1:0]        cnt;
  logic [EW-1:0]     head;
  logic              pop;
  logic              room;
  logic              drain_empty;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign {out_addr, out_last, out_data} = head;

  // Issue only if held + in-flight words, after this cycle's pop, leave a slot
  // for the new read. Depends on out_ready, so the strobe is combinational.
  assign room      = ({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign mem_rd_en = (state == READ) && (rem != '0) && room;

  // Empty once this cycle's pop completes: done lands the cycle after the last accept.
  assign drain_empty = !inflight && ((cnt == 2'd0) || ((cnt == 2'd1) && pop));

  mem_dump_skid #(.W(EW)) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (inflight),
    .din     ({fl_addr, fl_last, mem_rdata}),
    .pop     (pop),
    .head    (head),
    .cnt     (cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      mem_addr <= '0;
      inflight <= 1'b0;
      fl_addr  <= '0;
      fl_last  <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      done     <= 1'b0;
      if (mem_rd_en) begin
        fl_addr  <= mem_addr;
        fl_last  <= (rem == LEN_W'(1));
        mem_addr <= mem_addr + ADDR_W'(1);
        rem      <= rem - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= base;
            rem      <= len;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (mem_rd_en && (rem == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (pop)                    checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base = '0;
  logic [12:0] len = '0;
  logic        busy, done, mem_rd_en, out_valid, out_last;
  logic [11:0] mem_addr, out_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_dump_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
`ifdef MEM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  // memory model: synchronous read, 1-cycle latency
  logic [31:0] mem [0:4095];
  always @(posedge clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct { int a; logic [31:0] d; bit l; } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  bit rand_ready = 0;
  logic [31:0] exp_sum = '0;

  // monitor state
  bit  done_pend = 0, done_seen = 0, hold_pend = 0, wait_first = 0;
  logic [44:0] hold_val;
  int  issued = 0, accepted = 0, rd_cnt = 0, acc_cnt = 0;
  int  start_cyc = 0, first_valid_cyc = 0, first_acc_cyc = 0, last_acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // scoreboard / protocol monitor
  always @(negedge clock) begin
    bit pop, nd;
    exp_t e;
    if (!reset_n) begin
      done_pend = 0; hold_pend = 0; issued = 0; accepted = 0;
    end else begin
      pop = out_valid && out_ready;
      nd  = 0;
      if (hold_pend) check("hold_stable", {out_valid, out_addr, out_last, out_data}, {1'b1, hold_val});
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_addr, out_last, out_data};
      if (done || done_pend) check("done_timing", done, done_pend);
      if (done) begin
        done_seen = 1;
`ifdef MEM_DUMP_CHECKSUM_EN
        check("checksum_at_done", checksum, exp_sum);
`endif
      end
      if (start && !busy && !done) begin
        start_cyc = cyc + 1; wait_first = 1;
        if (len == 0) nd = 1;
      end
      if (wait_first && out_valid) begin first_valid_cyc = cyc; wait_first = 0; end
      if (pop) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: addr %0d data %0d, none expected", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("word", {out_addr, out_last, out_data}, {e.a[11:0], e.l, e.d});
          if (e.l) nd = 1;
        end
        if (acc_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
        accepted++;
      end
      if (mem_rd_en) begin
        rd_cnt++; issued++;
        check("rd_outstanding_le2", (issued - accepted <= 2) && busy, 1);
      end
      done_pend = nd;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 20000) begin @(posedge clock); #1; n++; end
    if (busy || done) begin tests++; fails++; $display("FAIL idle_timeout: busy %0d done %0d", busy, done); end
  endtask

  task automatic issue_start(input int b, input int l);
    int a;
    exp_sum  = '0;
    for (int i = 0; i < l; i++) begin
      a = (b + i) % 4096;
      exp_q.push_back('{a, mem[a], i == l - 1});
      exp_sum += mem[a];
    end
    acc_cnt   = 0;
    done_seen = 0;
    @(posedge clock); #1;
    start = 1; base = 12'(b); len = 13'(l);
    @(posedge clock); #1;
    start = 0; base = $urandom; len = $urandom;
  endtask

  task automatic run_dump(input int b, input int l, input bit rnd, input bit extra_start);
    int rd0, n;
    wait_idle();
    rand_ready = rnd;
    rd0 = rd_cnt;
    issue_start(b, l);
    @(negedge clock);
    check("busy_after_start", busy, l != 0);
    if (extra_start) begin
      @(posedge clock); #1;
      start = 1; base = 12'(b + 100); len = 13'd7;
      @(posedge clock); #1;
      start = 0;
    end
    n = 0;
    while (!done_seen && n < l * 8 + 100) begin @(negedge clock); n++; end
    if (!done_seen) begin tests++; fails++; $display("FAIL done_timeout: len %0d", l); end
    @(negedge clock);
    check("reads_issued", rd_cnt - rd0, l);
    check("words_left", exp_q.size(), 0);
    exp_q.delete();
    rand_ready = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    // reset state
    #1;
    check("rst_outputs", {busy, done, mem_rd_en, out_valid, out_last, out_data, out_addr, mem_addr}, 0);
    #20; reset_n = 1;

    // basic 3-word dump, timing
    mem[0] = 10; mem[1] = 29; mem[2] = 39;
    run_dump(0, 3, 0, 0);
    check("first_valid_latency", first_valid_cyc - start_cyc, 2);
    check("back_to_back", last_acc_cyc - first_acc_cyc, 2);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("checksum_78", checksum, 78);
`endif

    // wrap around top of memory
    mem[4094] = 7; mem[4095] = 8; mem[0] = 1; mem[1] = 2;
    run_dump(4094, 4, 0, 0);
    mem[0] = 10; mem[1] = 29; mem[2] = 39;

    // backpressure
    run_dump(0, 5, 1, 0);
    // empty dump
    run_dump(37, 0, 0, 0);
    // start while busy ignored
    run_dump(0, 3, 0, 1);

    // async reset after 2nd word accepted
    wait_idle();
    issue_start(0, 3);
    n = 0;
    while (acc_cnt < 2 && n < 50) begin @(negedge clock); n++; end
    @(posedge clock); #3;
    reset_n = 0;
    #1;
    check("rst_mid_outputs", {busy, done, mem_rd_en, out_valid, out_last, out_data, out_addr, mem_addr}, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("rst_mid_checksum", checksum, 0);
`endif
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1;
    run_dump(0, 2, 0, 0);

    // checksum wrap
    mem[100] = 4235; mem[101] = 32'hFFFF_FFFF;
    run_dump(100, 2, 1, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("checksum_wrap", checksum, 4234);
`endif

    // random dumps
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 64; i++) mem[$urandom_range(0, 4095)] = $urandom;
      run_dump($urandom_range(0, 4095), $urandom_range(0, 24), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // full-memory dump
    run_dump($urandom_range(0, 4095), 4096, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
